// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory behind a valid/ready request
// channel and a valid/ready response channel, with a fixed programmable
// access latency. One transaction in flight at a time; busy_o tells the
// hazard logic to hold the pipeline while an access is outstanding.
//
// Parameters:
//   DEPTH_WORDS - number of 32-bit words (power of 2, >= 2)
//   LATENCY     - cycles from accept edge to rsp_valid_o rising (>= 1)
//
// Ports:
//   clk_i, rst_i         - clock, synchronous active-high reset
//   req_valid_i/ready_o  - request handshake
//   req_write_i          - 1 = store, 0 = load
//   req_addr_i           - byte address (wraps modulo DEPTH_WORDS*4)
//   req_wdata_i          - store data
//   rsp_valid_o/ready_i  - response handshake
//   rsp_rdata_o          - load data, 0 for stores
//   rsp_err_o            - misaligned-access flag
//   busy_o               - transaction outstanding
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   - misaligned requests complete with rsp_err_o=1, rdata 0,
//               and stores are dropped
//   undefined - low address bits ignored, rsp_err_o tied to 0
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W    = $clog2(LATENCY) + 1;
    localparam int unsigned CNT_INIT = (LATENCY >= 2) ? (LATENCY - 2) : 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mis_q, mis_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               mem_we_c;
    logic               enter_resp_c;
    logic               mis_c;

    logic [31:0] mem [DEPTH_WORDS];

    // Misalignment detect on the incoming address
`ifdef DMEM_MISALIGN_CHECK_EN
    assign mis_c = |req_addr_i[1:0];
`else
    assign mis_c = 1'b0;
`endif

    // Address bits outside the word index are intentionally ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr_i[31:IDX_W+2], req_addr_i[1:0]};

    // Next-state and commit logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        idx_d        = idx_q;
        mis_d        = mis_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        mem_we_c     = 1'b0;
        enter_resp_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    wr_d    = req_write_i;
                    idx_d   = req_addr_i[IDX_W+1:2];
                    mis_d   = mis_c;
                    wdata_d = req_wdata_i;
                    if (LATENCY == 1) begin
                        state_d      = ST_RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(CNT_INIT);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = ST_RESP;
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The _d request fields hold the live request on a LATENCY==1
        // accept and the latched request otherwise.
        if (enter_resp_c) begin
            err_d = mis_d;
            if (wr_d) begin
                mem_we_c = !mis_d;
                rdata_d  = 32'd0;
            end else begin
                rdata_d = mis_d ? 32'd0 : mem[idx_d];
            end
        end

        // Reset overrides everything, so a pending store never commits
        if (rst_i) begin
            mem_we_c = 1'b0;
        end
    end

    // State and response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory array, not cleared by reset
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem[idx_d] <= wdata_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance a uses LATENCY=2, instance b
// uses LATENCY=1. Inputs change and outputs are sampled 1ns after each
// rising edge.
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    logic        a_req_valid, a_req_write, a_req_ready;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid, b_req_write, b_req_ready;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
    logic [31:0] b_rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        bz;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) u_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (a_req_valid),
        .req_write_i (a_req_write),
        .req_addr_i  (a_req_addr),
        .req_wdata_i (a_req_wdata),
        .req_ready_o (a_req_ready),
        .rsp_valid_o (a_rsp_valid),
        .rsp_ready_i (a_rsp_ready),
        .rsp_rdata_o (a_rsp_rdata),
        .rsp_err_o   (a_rsp_err),
        .busy_o      (a_busy)
    );

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) u_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (b_req_valid),
        .req_write_i (b_req_write),
        .req_addr_i  (b_req_addr),
        .req_wdata_i (b_req_wdata),
        .req_ready_o (b_req_ready),
        .rsp_valid_o (b_rsp_valid),
        .rsp_ready_i (b_rsp_ready),
        .rsp_rdata_o (b_rsp_rdata),
        .rsp_err_o   (b_rsp_err),
        .busy_o      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance a; lat counts edges from accept to
    // rsp_valid (bounded), bz is busy sampled right after the accept edge.
    task automatic txn_a(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         output int lat_o, output logic [31:0] rd_o, output logic er_o,
                         output logic bz_o);
        a_req_valid = 1'b1;
        a_req_write = w;
        a_req_addr  = addr;
        a_req_wdata = data;
        a_rsp_ready = 1'b0;
        tick();
        a_req_valid = 1'b0;
        bz_o  = a_busy;
        lat_o = 1;
        while (!a_rsp_valid && lat_o < 20) begin
            tick();
            lat_o++;
        end
        rd_o = a_rsp_rdata;
        er_o = a_rsp_err;
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_req_ready", 32'(a_req_ready), 32'd1);
        check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_busy",      32'(a_busy),      32'd0);
        check("rst_rdata",     a_rsp_rdata,      32'd0);
        check("rst_err",       32'(a_rsp_err),   32'd0);

        // 1: store then load, LATENCY=2
        txn_a(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, bz);
        check("st_lat",   32'(lat), 32'd2);
        check("st_rdata", rd,       32'd0);
        check("st_err",   32'(er),  32'd0);
        check("st_busy",  32'(bz),  32'd1);
        check("st_idle_busy",  32'(a_busy),      32'd0);
        check("st_idle_ready", 32'(a_req_ready), 32'd1);
        txn_a(1'b0, 32'h10, 32'h0, lat, rd, er, bz);
        check("ld_lat",   32'(lat), 32'd2);
        check("ld_rdata", rd,       32'hDEADBEEF);
        check("ld_busy",  32'(bz),  32'd1);

        // 2: back-pressure with a concurrent request that must be ignored
        txn_a(1'b1, 32'h4, 32'h00000044, lat, rd, er, bz);
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h10;
        tick();
        a_req_valid = 1'b0;
        tick();
        check("bp_valid_rise", 32'(a_rsp_valid), 32'd1);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h4; a_req_wdata = 32'h99;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(a_rsp_valid), 32'd1);
            check("bp_rdata", a_rsp_rdata,      32'hDEADBEEF);
            check("bp_ready", 32'(a_req_ready), 32'd0);
            tick();
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
        check("bp_done_valid", 32'(a_rsp_valid), 32'd0);
        check("bp_done_ready", 32'(a_req_ready), 32'd1);
        check("bp_done_busy",  32'(a_busy),      32'd0);
        txn_a(1'b0, 32'h4, 32'h0, lat, rd, er, bz);
        check("bp_no_accept", rd, 32'h00000044);

        // 3: address wrap
        txn_a(1'b1, 32'h200, 32'h11111111, lat, rd, er, bz);
        txn_a(1'b0, 32'h0, 32'h0, lat, rd, er, bz);
        check("wrap_rdata", rd, 32'h11111111);

        // 4: reset during WAIT drops the store
        txn_a(1'b1, 32'h20, 32'hA5A5A5A5, lat, rd, er, bz);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h5A5A5A5A;
        tick();
        a_req_valid = 1'b0;
        check("rw_busy_wait", 32'(a_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_valid", 32'(a_rsp_valid), 32'd0);
        check("rw_ready", 32'(a_req_ready), 32'd1);
        check("rw_busy",  32'(a_busy),      32'd0);
        tick();
        check("rw_valid_later", 32'(a_rsp_valid), 32'd0);
        txn_a(1'b0, 32'h20, 32'h0, lat, rd, er, bz);
        check("rw_rdata", rd, 32'hA5A5A5A5);

        // 5: misaligned store
        txn_a(1'b1, 32'h13, 32'hCAFEF00D, lat, rd, er, bz);
        check("mis_lat",   32'(lat), 32'd2);
        check("mis_rdata", rd,       32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_err", 32'(er), 32'd1);
        txn_a(1'b0, 32'h10, 32'h0, lat, rd, er, bz);
        check("mis_word", rd,       32'hDEADBEEF);
        check("mis_aligned_err", 32'(er), 32'd0);
`else
        check("mis_err", 32'(er), 32'd0);
        txn_a(1'b0, 32'h10, 32'h0, lat, rd, er, bz);
        check("mis_word", rd, 32'hCAFEF00D);
`endif

        // 6: LATENCY=1 instance, preload then back-to-back loads
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h4; b_req_wdata = 32'h00000404;
        tick();
        b_req_valid = 1'b0;
        check("l1_st_valid", 32'(b_rsp_valid), 32'd1);
        check("l1_st_rdata", b_rsp_rdata,      32'd0);
        tick();
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'h00000808;
        tick();
        b_req_valid = 1'b0;
        tick();
        check("l1_idle", 32'(b_req_ready), 32'd1);

        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h4;
        tick();
        check("l1_ld0_valid", 32'(b_rsp_valid), 32'd1);
        check("l1_ld0_rdata", b_rsp_rdata,      32'h00000404);
        check("l1_ld0_ready", 32'(b_req_ready), 32'd0);
        b_req_addr = 32'h8;
        tick();
        check("l1_gap_valid", 32'(b_rsp_valid), 32'd0);
        check("l1_gap_ready", 32'(b_req_ready), 32'd1);
        tick();
        b_req_valid = 1'b0;
        check("l1_ld1_valid", 32'(b_rsp_valid), 32'd1);
        check("l1_ld1_rdata", b_rsp_rdata,      32'h00000808);
        tick();
        check("l1_end_busy", 32'(b_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Target side of the CPU data-memory port: a word-organised data memory serving the load/store stage through a valid/ready request channel and a valid/ready response channel. Memory access takes a programmable number of cycles. busy_o goes to the hazard logic so the pipeline can hold PC, IF/ID and EXE/MEM while an access is outstanding. It replaces the single-cycle data memory where variable-latency memory is modelled.

Parameters:
DEPTH_WORDS, 128, number of 32-bit words; must be a power of 2.
LATENCY, 2, cycles from request accept edge to rsp_valid_o rising; must be >= 1.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous reset, active-high
req_valid_i  input  1  request present
req_write_i  input  1  1 = store, 0 = load
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data
req_ready_o  output  1  responder can accept a request
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  requester takes the response
rsp_rdata_o  output  32  load data; 0 for stores
rsp_err_o  output  1  access error flag (see Optional Feature)
busy_o  output  1  transaction outstanding; stall request to the pipeline

Behaviour:
- FSM states: IDLE, WAIT, RESP. req_ready_o = (state==IDLE). busy_o = (state!=IDLE). rsp_valid_o = (state==RESP).
- Reset: state IDLE, wait counter 0, rsp_rdata_o 0, rsp_err_o 0, latched request cleared. So after reset req_ready_o=1, rsp_valid_o=0, busy_o=0. Memory array contents are not cleared.
- Reset is sampled before all other conditions. A reset in WAIT abandons the transaction, and a pending store is never committed. A reset in RESP drops the response.
- Accept: in IDLE with req_valid_i=1, on the edge, latch write flag, address and wdata.
  - LATENCY==1: go to RESP.
  - Otherwise go to WAIT with counter = LATENCY-2.
- WAIT: counter decrements each cycle. At counter==0 the next edge goes to RESP. req_valid_i is ignored.
- Commit happens on the edge entering RESP:
  - Store: mem[idx] <= wdata, and rsp_rdata_o <= 0.
  - Load: rsp_rdata_o <= mem[idx].
  - rsp_valid_o is therefore high exactly LATENCY cycles after the accept edge.
- idx = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- RESP: rsp_rdata_o and rsp_err_o hold stable while rsp_ready_i=0, with no limit on back-pressure. When rsp_ready_i=1 the next edge goes to IDLE.
- No overlap: a new request can be accepted no earlier than the cycle after the response handshake, so the minimum transaction period is LATENCY+1 cycles.
- Ordering: a load following a store to the same word returns the stored data.
- Counter width is $clog2(LATENCY)+1. No arithmetic overflow is possible.

Optional Feature:
DMEM_MISALIGN_CHECK_EN.
- Defined: a request with req_addr_i[1:0]!=0 completes with normal timing but with rsp_err_o=1 and rsp_rdata_o=0, and a store does not modify memory. Aligned accesses get rsp_err_o=0.
- Undefined: req_addr_i[1:0] is ignored, the access goes to the containing word, and rsp_err_o is tied to 0.

Test Plan:
1. LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 -> each rsp_valid_o rises 2 cycles after its accept edge; load rdata=0xDEADBEEF; store rdata=0; busy_o high from the cycle after accept until the response handshake.
2. Back-pressure: load 0x10 with rsp_ready_i held low 5 cycles -> rsp_valid_o=1 and rdata=0xDEADBEEF stable all 5 cycles; req_ready_o=0 and a concurrent req_valid_i is not accepted; return to IDLE one edge after rsp_ready_i=1.
3. Wrap: store 0x11111111 to 0x200 with DEPTH_WORDS=128, then load 0x0 -> rdata=0x11111111.
4. Reset mid-WAIT: word 0x20 holds 0xA5A5A5A5; accept a store of 0x5A5A5A5A to 0x20, assert rst_i the next cycle -> rsp_valid_o=0, req_ready_o=1 after reset; a later load of 0x20 returns 0xA5A5A5A5.
5. Misalign: store 0xCAFEF00D to 0x13 -> with DMEM_MISALIGN_CHECK_EN, rsp_err_o=1 and word 0x10 unchanged; without it, rsp_err_o=0 and a load of 0x10 returns 0xCAFEF00D.
6. LATENCY=1: back-to-back loads at 0x4 and 0x8 with rsp_ready_i=1 -> each response 1 cycle after its accept; accepts 2 cycles apart.
